regfile_wb_arbiter: RTL and testbench

//  Shares the register file's single write port between NUM_REQ writeback sources (ALU, load unit, ...).

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_wb_arbiter_grant.sv | 61 ++++++
 rtl/regfile_wb_arbiter.sv | 102 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: default widths and shared types for the register-file writeback path.
package regfile_pkg;

  localparam int RF_DATA_WIDTH    = 32;
  localparam int RF_NUM_REGISTERS = 32;
  localparam int RF_ADDR_W        = $clog2(RF_NUM_REGISTERS);

  typedef logic [RF_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t                rd;
    logic [RF_DATA_WIDTH-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_grant.sv
// wb_grant_arbiter: one-hot grant over the occupied writeback buffers.
// REGFILE_WB_RR_EN selects round-robin with a pointer kept here; otherwise fixed priority, index 0 first.
module wb_grant_arbiter #(
  parameter int NUM_REQ = 2
) (
`ifdef REGFILE_WB_RR_EN
  input  logic               clk,
  input  logic               rst,
`endif
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant
);

  logic found;

`ifdef REGFILE_WB_RR_EN
  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0] ptr_q, ptr_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant = '0;
    found = 1'b0;
    ptr_d = ptr_q;
    // Two passes: indices at/after the pointer first, then the wrapped-around ones.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && i >= int'(ptr_q)) begin
        grant[i] = 1'b1;
        found    = 1'b1;
        ptr_d    = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && i < int'(ptr_q)) begin
        grant[i] = 1'b1;
        found    = 1'b1;
        ptr_d    = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`else
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: per-source one-entry buffers drained through a single registered regfile write port.
// Grant policy is round-robin when REGFILE_WB_RR_EN is defined, fixed priority (index 0 first) otherwise.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter  int DATA_WIDTH    = RF_DATA_WIDTH,
  parameter  int NUM_REGISTERS = RF_NUM_REGISTERS,
  parameter  int NUM_REQ       = 2,
  localparam int ADDR_W        = $clog2(NUM_REGISTERS)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]     req_reg,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data,
  output logic                               wr_en,
  output logic [ADDR_W-1:0]                  reg_wr,
  output logic [DATA_WIDTH-1:0]              data_in,
  output logic [NUM_REGISTERS-1:0]           pending_mask
);

  // Same shape as wb_req_t, sized by this instance's parameters.
  typedef struct packed {
    logic [ADDR_W-1:0]     rd;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  logic [NUM_REQ-1:0]       buf_v_q, buf_v_d, grant, xfer;
  entry_t [NUM_REQ-1:0]     buf_q, buf_d;
  logic                     wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]        reg_wr_q, reg_wr_d;
  logic [DATA_WIDTH-1:0]    data_in_q, data_in_d;
  logic [NUM_REGISTERS-1:0] pend_q, pend_d;

  wb_grant_arbiter #(.NUM_REQ(NUM_REQ)) u_grant (
`ifdef REGFILE_WB_RR_EN
    .clk   (clk),
    .rst   (rst),
`endif
    .req   (buf_v_q),
    .grant (grant)
  );

  always_comb begin
    req_ready = ~buf_v_q | grant;
    xfer      = req_valid & req_ready;
    buf_v_d   = buf_v_q & ~grant;
    buf_d     = buf_q;
    wr_en_d   = |grant;
    reg_wr_d  = reg_wr_q;
    data_in_d = data_in_q;
    pend_d    = pend_q;

    if (wr_en_q) pend_d[reg_wr_q] = 1'b0;

    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        reg_wr_d  = buf_q[i].rd;
        data_in_d = buf_q[i].data;
      end
    end

    // Writes to r0 are accepted and dropped; a set after the clear wins on the same bit.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (xfer[i] && req_reg[i] != '0) begin
        buf_v_d[i]         = 1'b1;
        buf_d[i].rd        = req_reg[i];
        buf_d[i].data      = req_data[i];
        pend_d[req_reg[i]] = 1'b1;
      end
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_v_q   <= '0;
      wr_en_q   <= 1'b0;
      reg_wr_q  <= '0;
      data_in_q <= '0;
      pend_q    <= '0;
    end else begin
      buf_v_q   <= buf_v_d;
      wr_en_q   <= wr_en_d;
      reg_wr_q  <= reg_wr_d;
      data_in_q <= data_in_d;
      pend_q    <= pend_d;
    end
  end

  // NOTE: buffer payload needs no reset; it is never used while its valid bit is clear.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign wr_en        = wr_en_q;
  assign reg_wr       = reg_wr_q;
  assign data_in      = data_in_q;
  assign pending_mask = pend_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
// Build with or without REGFILE_WB_RR_EN; the model follows the same macro.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int N  = 2;
  localparam int DW = RF_DATA_WIDTH;
  localparam int NR = RF_NUM_REGISTERS;
  localparam int AW = RF_ADDR_W;
`ifdef REGFILE_WB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N-1:0]           req_valid, req_ready;
  logic [N-1:0][AW-1:0]   req_reg;
  logic [N-1:0][DW-1:0]   req_data;
  logic                   wr_en;
  logic [AW-1:0]          reg_wr;
  logic [DW-1:0]          data_in;
  logic [NR-1:0]          pending_mask;

  int n_vec = 0;
  int n_err = 0;

  regfile_wb_arbiter #(.DATA_WIDTH(DW), .NUM_REGISTERS(NR), .NUM_REQ(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_reg      (req_reg),
    .req_data     (req_data),
    .wr_en        (wr_en),
    .reg_wr       (reg_wr),
    .data_in      (data_in),
    .pending_mask (pending_mask)
  );

  always #5 clk = ~clk;

  // Register file fed by the DUT's write port; r0 is hardwired to zero.
  logic [DW-1:0] tb_rf [NR] = '{default: '0};
  always @(posedge clk) if (wr_en === 1'b1 && reg_wr != '0) tb_rf[reg_wr] <= data_in;

  // Reference model: buffered entries, the write port, pending set and the ideal regfile.
  bit            m_bv [N];
  wb_req_t       m_buf [N];
  int            m_ptr = 0;
  bit            m_wr_en = 1'b0;
  logic [AW-1:0] m_reg_wr = '0;
  logic [DW-1:0] m_data_in = '0;
  logic [NR-1:0] m_pend = '0;
  logic [DW-1:0] m_rf [NR] = '{default: '0};
  logic [N-1:0]  m_acc;

  function automatic int m_pick();
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = RR ? (m_ptr + k) % N : k;
      if (m_bv[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_ready();
    logic [N-1:0] r;
    int g;
    g = m_pick();
    for (int i = 0; i < N; i++) r[i] = !m_bv[i] || (g == i);
    return r;
  endfunction

  // Applies one cycle of inputs, crosses one posedge, and advances the model; returns #1 after the edge.
  task automatic step(input logic r, input logic [N-1:0] v,
                      input logic [N-1:0][AW-1:0] rg, input logic [N-1:0][DW-1:0] dt);
    int g;
    rst       = r;
    req_valid = v;
    req_reg   = rg;
    req_data  = dt;
    g         = m_pick();
    m_acc     = v & m_ready();
    @(posedge clk);
    if (m_wr_en && m_reg_wr != '0) m_rf[m_reg_wr] = m_data_in;
    if (r) begin
      for (int i = 0; i < N; i++) m_bv[i] = 1'b0;
      m_ptr = 0; m_wr_en = 1'b0; m_reg_wr = '0; m_data_in = '0; m_pend = '0;
    end else begin
      if (m_wr_en) m_pend[m_reg_wr] = 1'b0;
      if (g >= 0) begin
        m_wr_en = 1'b1; m_reg_wr = m_buf[g].rd; m_data_in = m_buf[g].data;
        m_bv[g] = 1'b0; m_ptr = (g + 1) % N;
      end else begin
        m_wr_en = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (m_acc[i] && rg[i] != '0) begin
          m_bv[i] = 1'b1; m_buf[i] = '{rd: rg[i], data: dt[i]}; m_pend[rg[i]] = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, '0, '0, '0);
  endtask

  task automatic test_reset();
    step(1'b1, '1, {5'd3, 5'd4}, {32'h1, 32'h2});
    step(1'b1, '1, {5'd3, 5'd4}, {32'h1, 32'h2});
    n_vec++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
    n_vec++; if (pending_mask !== '0) begin n_err++; $display("FAIL reset_pending got=%h exp=0", pending_mask); end
    n_vec++; if (reg_wr !== '0 || data_in !== '0) begin n_err++; $display("FAIL reset_outputs got=%0d/%h exp=0/0", reg_wr, data_in); end
    n_vec++; if (req_ready !== 2'b11) begin n_err++; $display("FAIL reset_ready got=%b exp=11", req_ready); end
    idle();
    n_vec++; if (wr_en !== 1'b0 || pending_mask !== '0) begin n_err++; $display("FAIL reset_release got=%b/%h exp=0/0", wr_en, pending_mask); end
  endtask

  task automatic single_write(input logic [AW-1:0] rd, input logic [DW-1:0] val, input string tag);
    step(1'b0, 2'b01, {5'd0, rd}, {32'h0, val});
    n_vec++; if (pending_mask[rd] !== 1'b1 || wr_en !== 1'b0) begin n_err++; $display("FAIL %s_accept pend=%b wr_en=%b exp=1/0", tag, pending_mask[rd], wr_en); end
    idle();
    n_vec++; if (wr_en !== 1'b1 || reg_wr !== rd || data_in !== val) begin n_err++; $display("FAIL %s_write got=%b/%0d/%h exp=1/%0d/%h", tag, wr_en, reg_wr, data_in, rd, val); end
    idle();
    n_vec++; if (wr_en !== 1'b0 || pending_mask[rd] !== 1'b0) begin n_err++; $display("FAIL %s_commit wr_en=%b pend=%b exp=0/0", tag, wr_en, pending_mask[rd]); end
    n_vec++; if (tb_rf[rd] !== val) begin n_err++; $display("FAIL %s_readback got=%h exp=%h", tag, tb_rf[rd], val); end
  endtask

  task automatic test_single_write();
    single_write(5'd5, 32'hDEADBEEF, "single");
  endtask

  task automatic test_contention();
    logic [AW-1:0] first, second;
    first  = RR ? 5'd2 : 5'd1;
    second = RR ? 5'd1 : 5'd2;
    step(1'b0, 2'b11, {5'd2, 5'd1}, {32'h22, 32'h11});
    n_vec++; if (req_ready !== (RR ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL contend_ready got=%b exp=%b", req_ready, RR ? 2'b10 : 2'b01); end
    idle();
    n_vec++; if (wr_en !== 1'b1 || reg_wr !== first || data_in !== (first == 5'd1 ? 32'h11 : 32'h22)) begin n_err++; $display("FAIL contend_first got=%b/%0d/%h exp reg %0d", wr_en, reg_wr, data_in, first); end
    idle();
    n_vec++; if (wr_en !== 1'b1 || reg_wr !== second || data_in !== (second == 5'd1 ? 32'h11 : 32'h22)) begin n_err++; $display("FAIL contend_second got=%b/%0d/%h exp reg %0d", wr_en, reg_wr, data_in, second); end
    idle();
    n_vec++; if (wr_en !== 1'b0 || tb_rf[1] !== 32'h11 || tb_rf[2] !== 32'h22) begin n_err++; $display("FAIL contend_commit wr_en=%b r1=%h r2=%h exp=0/11/22", wr_en, tb_rf[1], tb_rf[2]); end
  endtask

  task automatic test_x0();
    n_vec++; if (req_ready[1] !== 1'b1) begin n_err++; $display("FAIL x0_ready got=%b exp=1", req_ready[1]); end
    step(1'b0, 2'b10, {5'd0, 5'd0}, {32'hFFFFFFFF, 32'h0});
    n_vec++; if (wr_en !== 1'b0 || pending_mask !== '0) begin n_err++; $display("FAIL x0_accept wr_en=%b pend=%h exp=0/0", wr_en, pending_mask); end
    idle();
    n_vec++; if (wr_en !== 1'b0 || pending_mask !== '0 || tb_rf[0] !== '0) begin n_err++; $display("FAIL x0_drop wr_en=%b pend=%h r0=%h exp=0/0/0", wr_en, pending_mask, tb_rf[0]); end
  endtask

  task automatic test_streaming();
    int c0, c1, nw, n1;
    c0 = 0; c1 = 0; nw = 0; n1 = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      step(1'b0, 2'b11, {AW'(16 + c1), AW'(8 + c0)}, {DW'($urandom), DW'($urandom)});
      if (m_acc[0]) c0++;
      if (m_acc[1]) c1++;
      n_vec++; if (wr_en !== m_wr_en || (m_wr_en && (reg_wr !== m_reg_wr || data_in !== m_data_in))) begin n_err++; $display("FAIL stream_cycle%0d got=%b/%0d/%h exp=%b/%0d/%h", cyc, wr_en, reg_wr, data_in, m_wr_en, m_reg_wr, m_data_in); end
      if (wr_en === 1'b1) begin
        nw++;
        if (reg_wr >= 5'd16) n1++;
      end
    end
    n_vec++; if (nw !== 7) begin n_err++; $display("FAIL stream_write_count got=%0d exp=7", nw); end
    n_vec++; if (n1 !== (RR ? 4 : 0)) begin n_err++; $display("FAIL stream_fairness req1_writes got=%0d exp=%0d", n1, RR ? 4 : 0); end
    for (int cyc = 0; cyc < 3; cyc++) begin
      idle();
      n_vec++; if (wr_en !== m_wr_en || (m_wr_en && (reg_wr !== m_reg_wr || data_in !== m_data_in))) begin n_err++; $display("FAIL stream_drain%0d got=%b/%0d/%h exp=%b/%0d/%h", cyc, wr_en, reg_wr, data_in, m_wr_en, m_reg_wr, m_data_in); end
    end
    n_vec++; if (pending_mask !== '0) begin n_err++; $display("FAIL stream_pending got=%h exp=0", pending_mask); end
  endtask

  task automatic test_reset_mid_op();
    step(1'b0, 2'b11, {5'd31, 5'd30}, {32'hA5A5A5A5, 32'h5A5A5A5A});
    n_vec++; if (pending_mask[31] !== 1'b1 || pending_mask[30] !== 1'b1) begin n_err++; $display("FAIL midrst_fill pend=%h exp bits 30,31 set", pending_mask); end
    step(1'b1, '0, '0, '0);
    n_vec++; if (wr_en !== 1'b0 || pending_mask !== '0 || req_ready !== 2'b11) begin n_err++; $display("FAIL midrst_clear got=%b/%h/%b exp=0/0/11", wr_en, pending_mask, req_ready); end
    for (int cyc = 0; cyc < 3; cyc++) begin
      idle();
      n_vec++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL midrst_quiet%0d wr_en got=%b exp=0", cyc, wr_en); end
    end
    n_vec++; if (tb_rf[30] !== '0 || tb_rf[31] !== '0) begin n_err++; $display("FAIL midrst_discard r30=%h r31=%h exp=0/0", tb_rf[30], tb_rf[31]); end
    single_write(5'd7, 32'h12345678, "post_reset");
  endtask

  task automatic test_random();
    logic [N-1:0][AW-1:0] rg;
    logic [N-1:0][DW-1:0] dt;
    logic [N-1:0]         v;
    logic                 r;
    for (int cyc = 0; cyc < 400; cyc++) begin
      r = ($urandom_range(0, 49) == 0);
      v = N'($urandom);
      for (int i = 0; i < N; i++) begin
        rg[i] = AW'($urandom_range(0, NR - 1));
        dt[i] = DW'($urandom);
      end
      step(r, v, rg, dt);
      n_vec++; if (req_ready !== m_ready()) begin n_err++; $display("FAIL rand%0d_ready got=%b exp=%b", cyc, req_ready, m_ready()); end
      n_vec++; if (wr_en !== m_wr_en) begin n_err++; $display("FAIL rand%0d_wr_en got=%b exp=%b", cyc, wr_en, m_wr_en); end
      n_vec++; if (reg_wr !== m_reg_wr) begin n_err++; $display("FAIL rand%0d_reg_wr got=%0d exp=%0d", cyc, reg_wr, m_reg_wr); end
      n_vec++; if (data_in !== m_data_in) begin n_err++; $display("FAIL rand%0d_data_in got=%h exp=%h", cyc, data_in, m_data_in); end
      n_vec++; if (pending_mask !== m_pend) begin n_err++; $display("FAIL rand%0d_pending got=%h exp=%h", cyc, pending_mask, m_pend); end
    end
    for (int cyc = 0; cyc < 4; cyc++) idle();
    for (int a = 0; a < NR; a++) begin
      n_vec++; if (tb_rf[a] !== m_rf[a]) begin n_err++; $display("FAIL rand_regfile r%0d got=%h exp=%h", a, tb_rf[a], m_rf[a]); end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) m_bv[i] = 1'b0;
    rst = 1'b1; req_valid = '0; req_reg = '0; req_data = '0;
    test_reset();
    test_single_write();
    test_contention();
    test_x0();
    test_streaming();
    test_reset_mid_op();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
